gesture_power_ctrl: RTL and testbench

Gesture-based power sequencer for the appliance's main power state. Recognises a two-key gesture inside a programmable window: left then right powers on, right then left powers off. The window length is the seconds value from the gesture-time setting block. Also honours a direct power key and suspends gesture recognition while the gesture time is being adjusted. Sits between the debounced one-shot key pulses and the power/mode logic; also drives the countdown display.

---
 rtl/gesture_power_ctrl.sv | 118 +++++++++++
 tb/tb_gesture_power_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gesture_power_ctrl.sv
// Gesture-based main power sequencer: left->right powers on, right->left powers off
// inside a latched window; also handles a direct power key and time-adjust suspension.
module gesture_power_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic [5:0] gesture_sec,
  input  logic       adjust_en,
  input  logic       left_press_once,
  input  logic       right_press_once,
  input  logic       power_key_press_once,
  output logic       power_on,
  output logic [1:0] state,
  output logic       arm_active,
  output logic [5:0] remain_sec,
  output logic       timeout_pulse
);

  localparam int unsigned TICK_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SEC_W    = 6;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]  SEC_MAX   = SEC_W'(59);

  // Encoding chosen so bit 1 is the power state and bit 0 marks an open window.
  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_ARM_ON  = 2'd1,
    S_ON      = 2'd2,
    S_ARM_OFF = 2'd3
  } state_t;

  state_t            state_q;
  logic [TICK_W-1:0] tick_q;
  logic [SEC_W-1:0]  remain_q;
  logic              timeout_q;

  logic              left_only_c;
  logic              right_only_c;
  logic              gesture_ok_c;
  logic [SEC_W-1:0]  window_len_c;
  logic              window_end_c;

  assign left_only_c  = left_press_once & ~right_press_once;
  assign right_only_c = right_press_once & ~left_press_once;
  assign gesture_ok_c = (gesture_sec != '0);
  assign window_len_c = (gesture_sec > SEC_MAX) ? SEC_MAX : gesture_sec;
  assign window_end_c = (remain_q == SEC_W'(1)) && (tick_q == TICK_LAST);

  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      state_q   <= S_OFF;
      tick_q    <= '0;
      remain_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (power_key_press_once) begin
        state_q  <= state_q[1] ? S_OFF : S_ON;
        tick_q   <= '0;
        remain_q <= '0;
      end else if (adjust_en) begin
        // Abandon any open window back to the state it started from.
        if (state_q == S_ARM_ON)  state_q <= S_OFF;
        if (state_q == S_ARM_OFF) state_q <= S_ON;
        tick_q   <= '0;
        remain_q <= '0;
      end else begin
        case (state_q)
          S_OFF: begin
            if (left_only_c && gesture_ok_c) begin
              state_q  <= S_ARM_ON;
              tick_q   <= '0;
              remain_q <= window_len_c;
            end
          end
          S_ON: begin
            if (right_only_c && gesture_ok_c) begin
              state_q  <= S_ARM_OFF;
              tick_q   <= '0;
              remain_q <= window_len_c;
            end
          end
          S_ARM_ON, S_ARM_OFF: begin
            if ((state_q == S_ARM_ON && right_only_c) ||
                (state_q == S_ARM_OFF && left_only_c)) begin
              state_q  <= (state_q == S_ARM_ON) ? S_ON : S_OFF;
              tick_q   <= '0;
              remain_q <= '0;
            end else if (window_end_c) begin
              state_q   <= (state_q == S_ARM_ON) ? S_OFF : S_ON;
              tick_q    <= '0;
              remain_q  <= '0;
              timeout_q <= 1'b1;
            end else if (tick_q == TICK_LAST) begin
              tick_q   <= '0;
              remain_q <= remain_q - SEC_W'(1);
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          default: begin
            state_q  <= S_OFF;
            tick_q   <= '0;
            remain_q <= '0;
          end
        endcase
      end
    end
  end

  assign state         = state_q;
  assign power_on      = state_q[1];
  assign arm_active    = state_q[0];
  assign remain_sec    = remain_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_gesture_power_ctrl.sv
// Directed bench for gesture_power_ctrl using hand-computed cycle expectations.
module tb_gesture_power_ctrl;

  logic       clk_100Hz = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] gesture_sec = '0;
  logic       adjust_en = 1'b0;
  logic       left_press_once = 1'b0;
  logic       right_press_once = 1'b0;
  logic       power_key_press_once = 1'b0;
  logic       power_on;
  logic [1:0] state;
  logic       arm_active;
  logic [5:0] remain_sec;
  logic       timeout_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int to_cnt = 0;
  int to_base;

  localparam logic [1:0] OFF = 2'd0, ARM_ON = 2'd1, ON = 2'd2, ARM_OFF = 2'd3;

  gesture_power_ctrl #(.TICKS_PER_SEC(100)) dut (
    .clk_100Hz            (clk_100Hz),
    .rst                  (rst),
    .gesture_sec          (gesture_sec),
    .adjust_en            (adjust_en),
    .left_press_once      (left_press_once),
    .right_press_once     (right_press_once),
    .power_key_press_once (power_key_press_once),
    .power_on             (power_on),
    .state                (state),
    .arm_active           (arm_active),
    .remain_sec           (remain_sec),
    .timeout_pulse        (timeout_pulse)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  // Counts cycles in which timeout_pulse was high.
  always @(posedge clk_100Hz) if (timeout_pulse === 1'b1) to_cnt <= to_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n clock edges; inputs driven afterwards apply to the new cycle.
  task automatic step(input int n);
    repeat (n) @(posedge clk_100Hz);
    #1;
  endtask

  task automatic key(input logic l, input logic r, input logic p);
    left_press_once = l;
    right_press_once = r;
    power_key_press_once = p;
    step(1);
    left_press_once = 1'b0;
    right_press_once = 1'b0;
    power_key_press_once = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    check_eq("rst_state", 32'(state), 32'(OFF));
    check_eq("rst_power", 32'(power_on), 0);
    check_eq("rst_remain", 32'(remain_sec), 0);
    check_eq("rst_timeout", 32'(timeout_pulse), 0);

    // Power-on gesture, gs=5, right at cycle 300
    gesture_sec = 6'd5;
    key(1, 0, 0);                                  // now cycle 1
    check_eq("arm_state", 32'(state), 32'(ARM_ON));
    check_eq("arm_remain", 32'(remain_sec), 5);
    check_eq("arm_active", 32'(arm_active), 1);
    step(249);                                     // cycle 250
    check_eq("remain_250", 32'(remain_sec), 3);
    step(50);                                      // cycle 300
    key(0, 1, 0);                                  // cycle 301
    check_eq("on_state", 32'(state), 32'(ON));
    check_eq("on_power", 32'(power_on), 1);
    check_eq("on_remain", 32'(remain_sec), 0);

    // Power-off window expires, gs=2
    gesture_sec = 6'd2;
    to_base = to_cnt;
    key(0, 1, 0);                                  // cycle 1
    check_eq("armoff_state", 32'(state), 32'(ARM_OFF));
    check_eq("armoff_power", 32'(power_on), 1);
    step(99);                                      // cycle 100
    check_eq("remain_100", 32'(remain_sec), 2);
    step(1);                                       // cycle 101
    check_eq("remain_101", 32'(remain_sec), 1);
    step(99);                                      // cycle 200
    check_eq("armoff_200", 32'(state), 32'(ARM_OFF));
    check_eq("power_200", 32'(power_on), 1);
    check_eq("to_200", 32'(timeout_pulse), 0);
    step(1);                                       // cycle 201
    check_eq("to_state_201", 32'(state), 32'(ON));
    check_eq("to_pulse_201", 32'(timeout_pulse), 1);
    check_eq("to_remain_201", 32'(remain_sec), 0);
    step(1);                                       // cycle 202
    check_eq("to_pulse_202", 32'(timeout_pulse), 0);
    check_eq("to_count", 32'(to_cnt - to_base), 1);

    // Boundary: completing key on cycle N wins
    key(0, 0, 1);
    check_eq("pk_off", 32'(state), 32'(OFF));
    to_base = to_cnt;
    key(1, 0, 0);                                  // cycle 1
    step(199);                                     // cycle 200
    key(0, 1, 0);                                  // cycle 201
    check_eq("bnd_state", 32'(state), 32'(ON));
    check_eq("bnd_pulse", 32'(timeout_pulse), 0);
    step(5);
    check_eq("bnd_hold", 32'(state), 32'(ON));
    check_eq("bnd_count", 32'(to_cnt - to_base), 0);

    // gs=0 disables; simultaneous keys ignored
    key(0, 0, 1);
    gesture_sec = 6'd0;
    key(1, 0, 0);
    check_eq("gs0_state", 32'(state), 32'(OFF));
    gesture_sec = 6'd5;
    key(1, 1, 0);
    check_eq("both_state", 32'(state), 32'(OFF));
    check_eq("both_remain", 32'(remain_sec), 0);

    // Power key and adjust mid-window
    to_base = to_cnt;
    key(1, 0, 0);
    step(50);
    key(0, 0, 1);
    check_eq("pk_mid_state", 32'(state), 32'(ON));
    check_eq("pk_mid_pulse", 32'(timeout_pulse), 0);
    check_eq("pk_mid_remain", 32'(remain_sec), 0);
    key(0, 0, 1);
    key(1, 0, 0);
    step(50);
    adjust_en = 1'b1;
    step(1);
    check_eq("adj_state", 32'(state), 32'(OFF));
    check_eq("adj_remain", 32'(remain_sec), 0);
    key(1, 0, 0);
    check_eq("adj_ignore_left", 32'(state), 32'(OFF));
    adjust_en = 1'b0;
    step(2);
    check_eq("abort_count", 32'(to_cnt - to_base), 0);

    // ARM_OFF completed by left
    key(0, 0, 1);
    key(0, 1, 0);
    step(10);
    key(1, 0, 0);
    check_eq("off_gesture", 32'(state), 32'(OFF));
    check_eq("off_power", 32'(power_on), 0);

    // Reset mid-window
    key(1, 0, 0);
    step(20);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("mrst_state", 32'(state), 32'(OFF));
    check_eq("mrst_remain", 32'(remain_sec), 0);
    check_eq("mrst_power", 32'(power_on), 0);
    check_eq("mrst_pulse", 32'(timeout_pulse), 0);

    // Window latched at arm; repeated left does not restart it
    gesture_sec = 6'd5;
    key(1, 0, 0);                                  // cycle 1
    step(99);                                      // cycle 100
    gesture_sec = 6'd9;
    step(100);                                     // cycle 200
    key(1, 0, 0);                                  // cycle 201
    step(299);                                     // cycle 500
    check_eq("latch_500_state", 32'(state), 32'(ARM_ON));
    check_eq("latch_500_remain", 32'(remain_sec), 1);
    step(1);                                       // cycle 501
    check_eq("latch_501_state", 32'(state), 32'(OFF));
    check_eq("latch_501_pulse", 32'(timeout_pulse), 1);
    step(1);
    check_eq("latch_502_pulse", 32'(timeout_pulse), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
